idex_pipeline: RTL

ID/EX pipeline register for the 5-stage MIPS core, with integrated load-use hazard detection. It sits between the register-file/decode stage and the execute stage. It captures decode operands and control each cycle. It inserts a one-cycle bubble on a load-use dependency and gates PC and IF/ID writes. It supplies the IDEXRs/IDEXRt/IDEXRd fields that the downstream forwarding unit compares against EX/MEM and MEM/WB destinations.

---
 rtl/idex_pipeline.sv | 98 +++++++++
 1 files changed

// File: rtl/idex_pipeline.sv
// idex_pipeline: ID/EX pipeline register with load-use hazard detection, bubble insertion
// and a saturating count of the load-use bubbles it inserts.
module idex_pipeline #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              Hold,
    input  logic              Flush,
    input  logic [4:0]        IFIDRs,
    input  logic [4:0]        IFIDRt,
    input  logic [4:0]        IFIDRd,
    input  logic [DATA_W-1:0] ReadData1,
    input  logic [DATA_W-1:0] ReadData2,
    input  logic [DATA_W-1:0] SignExtImm,
    input  logic [5:0]        Funct,
    input  logic              RegWrite,
    input  logic              MemtoReg,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic              Branch,
    input  logic              ALUSrc,
    input  logic              RegDst,
    input  logic [1:0]        ALUOp,
    output logic [4:0]        IDEXRs,
    output logic [4:0]        IDEXRt,
    output logic [4:0]        IDEXRd,
    output logic [DATA_W-1:0] IDEXData1,
    output logic [DATA_W-1:0] IDEXData2,
    output logic [DATA_W-1:0] IDEXImm,
    output logic [5:0]        IDEXFunct,
    output logic [1:0]        IDEXALUOp,
    output logic              IDEXRegWrite,
    output logic              IDEXMemtoReg,
    output logic              IDEXMemRead,
    output logic              IDEXMemWrite,
    output logic              IDEXBranch,
    output logic              IDEXALUSrc,
    output logic              IDEXRegDst,
    output logic              IDEXValid,
    output logic              PCWrite,
    output logic              IFIDWrite,
    output logic [CNT_W-1:0]  StallCount
);
    logic w_load_use;
    logic w_stall;
    logic w_bubble;

    assign w_load_use = !rst && IDEXMemRead && IDEXValid && (IDEXRt != 5'd0) &&
                        (IDEXRt == IFIDRs || IDEXRt == IFIDRt);
    // A coincident flush already squashes the dependent instruction, so no stall is needed.
    assign w_stall    = w_load_use && !Flush;
    assign w_bubble   = Flush || w_load_use;
    assign PCWrite    = !Hold && !w_stall;
    assign IFIDWrite  = !Hold && !w_stall;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            IDEXRs       <= '0;
            IDEXRt       <= '0;
            IDEXRd       <= '0;
            IDEXData1    <= '0;
            IDEXData2    <= '0;
            IDEXImm      <= '0;
            IDEXFunct    <= '0;
            IDEXALUOp    <= '0;
            IDEXRegWrite <= 1'b0;
            IDEXMemtoReg <= 1'b0;
            IDEXMemRead  <= 1'b0;
            IDEXMemWrite <= 1'b0;
            IDEXBranch   <= 1'b0;
            IDEXALUSrc   <= 1'b0;
            IDEXRegDst   <= 1'b0;
            IDEXValid    <= 1'b0;
            StallCount   <= '0;
        end else if (!Hold) begin
            IDEXRs       <= w_bubble ? 5'd0 : IFIDRs;
            IDEXRt       <= w_bubble ? 5'd0 : IFIDRt;
            IDEXRd       <= w_bubble ? 5'd0 : IFIDRd;
            IDEXData1    <= w_bubble ? '0 : ReadData1;
            IDEXData2    <= w_bubble ? '0 : ReadData2;
            IDEXImm      <= w_bubble ? '0 : SignExtImm;
            IDEXFunct    <= w_bubble ? 6'd0 : Funct;
            IDEXALUOp    <= w_bubble ? 2'd0 : ALUOp;
            IDEXRegWrite <= !w_bubble && RegWrite;
            IDEXMemtoReg <= !w_bubble && MemtoReg;
            IDEXMemRead  <= !w_bubble && MemRead;
            IDEXMemWrite <= !w_bubble && MemWrite;
            IDEXBranch   <= !w_bubble && Branch;
            IDEXALUSrc   <= !w_bubble && ALUSrc;
            IDEXRegDst   <= !w_bubble && RegDst;
            IDEXValid    <= !w_bubble;
            if (w_stall && StallCount != {CNT_W{1'b1}})
                StallCount <= StallCount + 1'b1;
        end
    end
endmodule
